// File: rtl/rv_isa_pkg.sv
// RV32I ISA constants, op enumeration and encoder helper types shared with the decoder.
// Latency: none, definitions only.
// Backpressure: not applicable.
package rv_isa_pkg;

  // Base opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU funct3 (register and immediate forms share these)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Load/store width funct3
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef enum logic [5:0] {
    OP_BEQ   = 6'd0,  OP_BNE   = 6'd1,  OP_BLT   = 6'd2,  OP_BGE   = 6'd3,
    OP_BLTU  = 6'd4,  OP_BGEU  = 6'd5,  OP_ADD   = 6'd6,  OP_ADDI  = 6'd7,
    OP_SLTI  = 6'd8,  OP_OR    = 6'd9,  OP_ORI   = 6'd10, OP_XOR   = 6'd11,
    OP_XORI  = 6'd12, OP_AND   = 6'd13, OP_ANDI  = 6'd14, OP_SUB   = 6'd15,
    OP_SLTIU = 6'd16, OP_SLLI  = 6'd17, OP_SRLI  = 6'd18, OP_SRAI  = 6'd19,
    OP_SLL   = 6'd20, OP_SLT   = 6'd21, OP_SLTU  = 6'd22, OP_SRL   = 6'd23,
    OP_SRA   = 6'd24, OP_LUI   = 6'd25, OP_AUIPC = 6'd26, OP_JAL   = 6'd27,
    OP_JALR  = 6'd28, OP_LB    = 6'd29, OP_LH    = 6'd30, OP_LW    = 6'd31,
    OP_LBU   = 6'd32, OP_LHU   = 6'd33, OP_SB    = 6'd34, OP_SH    = 6'd35,
    OP_SW    = 6'd36, OP_ECALL = 6'd37
  } op_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } fifo_entry_t;

  // True when v equals the sign extension of v[msb:0], i.e. bits 31..msb all match.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/rv_encode_fields.sv
// Combinational RV32I field packer: symbolic op/regs/imm to a 32-bit word plus error flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
module rv_encode_fields
  import rv_isa_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal,
  output logic        range_err
);

  fmt_e       fmt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  // Classify the op into format, opcode, funct3 and funct7
  always_comb begin
    fmt     = FMT_R;
    opc     = OPC_OP;
    f3      = F3_ADD;
    f7      = F7_BASE;
    illegal = 1'b0;
    case (op)
      OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
      OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
      OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
      OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  end
      OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLL;  end
      OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLT;  end
      OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SLTU; end
      OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_XOR;  end
      OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   end
      OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; end
      OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_OR;   end
      OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = F3_AND;  end
      OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_ADD;  end
      OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLT;  end
      OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_SLTU; end
      OP_XORI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_XOR;  end
      OP_ORI:   begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_OR;   end
      OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OP_IMM; f3 = F3_AND;  end
      OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SLL;  end
      OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   end
      OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; end
      OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;    end
      OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC;  end
      OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;    end
      OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'b000;  end
      OP_LB:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_B;    end
      OP_LH:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_H;    end
      OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_W;    end
      OP_LBU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_BU;   end
      OP_LHU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_HU;   end
      OP_SB:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_B;    end
      OP_SH:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_H;    end
      OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_W;    end
      OP_ECALL: begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
      default:  illegal = 1'b1;
    endcase
  end

  // Pack fields per format; out-of-range immediates are truncated and flagged
  always_comb begin
    instr     = '0;
    range_err = 1'b0;
    if (!illegal) begin
      case (fmt)
        FMT_R: begin
          instr = {f7, rs2, rs1, f3, rd, opc};
        end
        FMT_I: begin
          instr     = {imm[11:0], rs1, f3, rd, opc};
          range_err = !sext_fits(imm, 11);
        end
        FMT_SH: begin
          instr     = {f7, imm[4:0], rs1, f3, rd, opc};
          range_err = (imm[31:5] != '0);
        end
        FMT_S: begin
          instr     = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
          range_err = !sext_fits(imm, 11);
        end
        FMT_B: begin
          instr     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
          range_err = !sext_fits(imm, 12) || imm[0];
        end
        FMT_U: begin
          instr     = {imm[31:12], rd, opc};
          range_err = (imm[11:0] != '0);
        end
        FMT_J: begin
          instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
          range_err = !sext_fits(imm, 20) || imm[0];
        end
        default: begin
          instr = ECALL_WORD;
        end
      endcase
    end
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Encodes RV32I requests into address-tagged instruction words through a 2-entry output queue.
// Latency: 1 cycle from accept to out_valid; error pulses appear the cycle after accept.
// Backpressure: in_ready drops while both entries are held; no same-cycle pop bypass.
module rv_instr_encoder
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  input  logic                 addr_load,
  input  logic [31:0]          addr_load_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_addr,
  output logic                 err_illegal,
  output logic                 err_range,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [31:0] enc_instr;
  logic        enc_illegal;
  logic        enc_range_err;

  fifo_entry_t fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [31:0] addr_cnt;
  logic [31:0] push_addr;
  logic        accept;
  logic        push;
  logic        pop;
  logic        err_event;

  rv_encode_fields u_fields (
    .op        (in_op),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .instr     (enc_instr),
    .illegal   (enc_illegal),
    .range_err (enc_range_err)
  );

  // Handshake, queue control and address selection for the entry being pushed
  always_comb begin
    in_ready  = (count != 2'd2);
    out_valid = (count != 2'd0);
    accept    = in_valid && in_ready;
    push      = accept && !enc_illegal;
    pop       = out_valid && out_ready;
    push_addr = addr_load ? addr_load_val : addr_cnt;
    err_event = accept && (enc_illegal || enc_range_err);
    out_instr = out_valid ? fifo_mem[rd_ptr].instr : '0;
    out_addr  = out_valid ? fifo_mem[rd_ptr].addr  : '0;
  end

  // Two-entry queue storage and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{instr: enc_instr, addr: push_addr};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Address counter: advances past each pushed word, or jumps on an explicit load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= BASE_ADDR;
    end else if (push) begin
      addr_cnt <= push_addr + 32'd4;
    end else if (addr_load) begin
      addr_cnt <= addr_load_val;
    end
  end

  // Error pulses for the accepted request and the saturating event counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= accept && enc_illegal;
      err_range   <= accept && !enc_illegal && enc_range_err;
      if (err_event && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed-vector bench for rv_instr_encoder with hand-computed instruction words.
// Latency: checks out_valid one cycle after accept and error pulses on that same cycle.
// Backpressure: exercises a full queue with out_ready low, then an in-order drain.
module tb_rv_instr_encoder;

  localparam logic [5:0] T_BEQ = 6'd0, T_ADD = 6'd6, T_ADDI = 6'd7, T_SUB = 6'd15;
  localparam logic [5:0] T_SRAI = 6'd19, T_LUI = 6'd25, T_JAL = 6'd27, T_SW = 6'd36;
  localparam logic [5:0] T_ECALL = 6'd37, T_BAD = 6'd45;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_load_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_illegal;
  logic        err_range;
  logic [7:0]  err_count;

  int tests = 0;
  int failed = 0;

  rv_instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .addr_load     (addr_load),
    .addr_load_val (addr_load_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_addr      (out_addr),
    .err_illegal   (err_illegal),
    .err_range     (err_range),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Present one request (called #1 after an edge), hold it over one accept edge, return #1 after it
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL send_ready_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, out_instr, out_addr} !== 65'd0) begin
      failed++;
      $display("FAIL reset_out valid=%b instr=%h addr=%h required 0/0/0", out_valid, out_instr, out_addr);
    end
    tests++;
    if ({err_illegal, err_range, err_count} !== 10'd0) begin
      failed++;
      $display("FAIL reset_err ill=%b rng=%b cnt=%0d required 0/0/0", err_illegal, err_range, err_count);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [5:0]  ops  [3];
    logic [31:0] exp_i[3];
    logic [31:0] exp_a[3];
    ops = '{T_ADDI, T_ADD, T_SUB};
    exp_i = '{32'h00500093, 32'h002081B3, 32'h402081B3};
    exp_a = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) send(ops[i], 5'd1, 5'd0, 5'd0, 32'd5);
      else        send(ops[i], 5'd3, 5'd1, 5'd2, 32'd0);
      tests++;
      if (out_valid !== 1'b1 || out_instr !== exp_i[i] || out_addr !== exp_a[i]) begin
        failed++;
        $display("FAIL alu_%0d valid=%b instr=%h addr=%h required 1/%h/%h",
                 i, out_valid, out_instr, out_addr, exp_i[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_formats();
    logic [5:0]  ops  [6];
    logic [4:0]  rds  [6];
    logic [4:0]  r1s  [6];
    logic [4:0]  r2s  [6];
    logic [31:0] imms [6];
    logic [31:0] exp_i[6];
    ops   = '{T_BEQ, T_SW, T_JAL, T_LUI, T_SRAI, T_ECALL};
    rds   = '{5'd0, 5'd0, 5'd1, 5'd5, 5'd1, 5'd0};
    r1s   = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0};
    r2s   = '{5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    imms  = '{32'd8, 32'd12, 32'd16, 32'h12345000, 32'd3, 32'd0};
    exp_i = '{32'h00208463, 32'h0020A623, 32'h010000EF, 32'h123452B7, 32'h4030D093, 32'h00000073};
    for (int i = 0; i < 6; i++) begin
      send(ops[i], rds[i], r1s[i], r2s[i], imms[i]);
      tests++;
      if (out_valid !== 1'b1 || out_instr !== exp_i[i] || out_addr !== 32'hC + 32'(4 * i)) begin
        failed++;
        $display("FAIL fmt_%0d valid=%b instr=%h addr=%h required 1/%h/%h",
                 i, out_valid, out_instr, out_addr, exp_i[i], 32'hC + 32'(4 * i));
      end
      tests++;
      if (err_range !== 1'b0 || err_illegal !== 1'b0) begin
        failed++;
        $display("FAIL fmt_err_%0d rng=%b ill=%b required 0/0", i, err_range, err_illegal);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_i[3];
    logic [31:0] got_a[3];
    int          n;
    logic        c_acc;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      failed++;
      $display("FAIL bp_one in_ready=%b out_valid=%b required 1/1", in_ready, out_valid);
    end
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
    tests++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("FAIL bp_full in_ready=%b required 0", in_ready);
    end
    in_valid = 1'b1; in_imm = 32'd3;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b0 || out_instr !== 32'h00100093 || out_addr !== 32'h24) begin
      failed++;
      $display("FAIL bp_hold in_ready=%b instr=%h addr=%h required 0/00100093/00000024",
               in_ready, out_instr, out_addr);
    end
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid && n < 3) begin
        got_i[n] = out_instr;
        got_a[n] = out_addr;
        n++;
      end
      c_acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (c_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tests++;
    if (n != 3 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL bp_drain_count popped=%0d out_valid=%b required 3/0", n, out_valid);
    end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got_i[i] !== ((32'(i + 1) << 20) | 32'h93) || got_a[i] !== 32'h24 + 32'(4 * i)) begin
        failed++;
        $display("FAIL bp_order_%0d instr=%h addr=%h required %h/%h", i, got_i[i], got_a[i],
                 (32'(i + 1) << 20) | 32'h93, 32'h24 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_illegal();
    send(T_BAD, 5'd1, 5'd1, 5'd1, 32'd0);
    tests++;
    if (err_illegal !== 1'b1 || out_valid !== 1'b0 || err_count !== 8'd1) begin
      failed++;
      $display("FAIL illegal_pulse ill=%b out_valid=%b cnt=%0d required 1/0/1",
               err_illegal, out_valid, err_count);
    end
    @(posedge clk); #1;
    tests++;
    if (err_illegal !== 1'b0 || err_count !== 8'd1) begin
      failed++;
      $display("FAIL illegal_one_cycle ill=%b cnt=%0d required 0/1", err_illegal, err_count);
    end
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd7);
    tests++;
    if (out_instr !== 32'h00700093 || out_addr !== 32'h30) begin
      failed++;
      $display("FAIL illegal_next instr=%h addr=%h required 00700093/00000030", out_instr, out_addr);
    end
  endtask

  task automatic test_range();
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
    tests++;
    if (err_range !== 1'b1 || out_instr !== 32'h00000093 || out_addr !== 32'h34 || err_count !== 8'd2) begin
      failed++;
      $display("FAIL range_addi rng=%b instr=%h addr=%h cnt=%0d required 1/00000093/00000034/2",
               err_range, out_instr, out_addr, err_count);
    end
    send(T_BEQ, 5'd0, 5'd1, 5'd2, 32'd3);
    tests++;
    if (err_range !== 1'b1 || out_instr !== 32'h00208163 || out_addr !== 32'h38 || err_count !== 8'd3) begin
      failed++;
      $display("FAIL range_beq rng=%b instr=%h addr=%h cnt=%0d required 1/00208163/00000038/3",
               err_range, out_instr, out_addr, err_count);
    end
    @(posedge clk); #1;
    tests++;
    if (err_range !== 1'b0) begin
      failed++;
      $display("FAIL range_one_cycle rng=%b required 0", err_range);
    end
  endtask

  task automatic test_addr_load();
    addr_load = 1'b1; addr_load_val = 32'h100;
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    addr_load = 1'b0;
    tests++;
    if (out_addr !== 32'h100) begin
      failed++;
      $display("FAIL load_push addr=%h required 00000100", out_addr);
    end
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
    tests++;
    if (out_addr !== 32'h104) begin
      failed++;
      $display("FAIL load_next addr=%h required 00000104", out_addr);
    end
    addr_load = 1'b1; addr_load_val = 32'h200;
    @(posedge clk); #1;
    addr_load = 1'b0;
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd3);
    tests++;
    if (out_addr !== 32'h200) begin
      failed++;
      $display("FAIL load_idle addr=%h required 00000200", out_addr);
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failed++;
      $display("FAIL mid_full out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== 32'd0 || err_count !== 8'd0) begin
      failed++;
      $display("FAIL mid_reset valid=%b instr=%h addr=%h cnt=%0d required 0/0/0/0",
               out_valid, out_instr, out_addr, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    tests++;
    if (out_instr !== 32'h00500093 || out_addr !== 32'h0) begin
      failed++;
      $display("FAIL mid_base instr=%h addr=%h required 00500093/00000000", out_instr, out_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_formats();
    test_backpressure();
    test_illegal();
    test_range();
    test_addr_load();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
